// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary (Stein) GCD datapath.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_CNT_W = 6;
  localparam int GCD_K_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_stein16_tzn16.sv
// Trailing-zero counter for a 16-bit word; count is 0 when the word is all zeros.
module tzn16 (
  input  logic [15:0] data_i,
  output logic [3:0]  count_o,
  output logic        all_zeros_o
);

  always_comb begin
    count_o     = 4'd0;
    all_zeros_o = (data_i == 16'd0);
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (data_i[i]) count_o = 4'(i);
    end
  end

endmodule

// File: rtl/gcd_stein16.sv
// Iterative binary (Stein) GCD engine with valid/ready handshakes on both sides.
// Optional build macro GCD_CYCLE_CNT_EN adds cycles_o, the LOOP-cycle count of the current result.
module gcd_stein16
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
`ifdef GCD_CYCLE_CNT_EN
  output logic [GCD_CNT_W-1:0] cycles_o,
`endif
  output logic [WIDTH-1:0] gcd_o
);

  gcd_state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q, gcd_q;
  logic [GCD_K_W-1:0] k_q;

  logic             ops_zero, loop_eq, a_gt_b;
  logic [WIDTH-1:0] diff, tz_src;
  logic [3:0]       tz_ab, tz_ad, tz_b;
  logic             ab_zero_unused, ad_zero_unused, b_zero_unused;

  assign ops_zero = (a_i == '0) || (b_i == '0);
  assign loop_eq  = (a_q == b_q);
  assign a_gt_b   = (a_q > b_q);
  assign diff     = a_gt_b ? (a_q - b_q) : (b_q - a_q);
  // One counter serves tz(A) at load time and tz(d) during iterations.
  assign tz_src   = (state_q == IDLE) ? a_i : diff;

  tzn16 u_tz_ab (
    .data_i      (a_i | b_i),
    .count_o     (tz_ab),
    .all_zeros_o (ab_zero_unused)
  );

  tzn16 u_tz_ad (
    .data_i      (tz_src),
    .count_o     (tz_ad),
    .all_zeros_o (ad_zero_unused)
  );

  tzn16 u_tz_b (
    .data_i      (b_i),
    .count_o     (tz_b),
    .all_zeros_o (b_zero_unused)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = ops_zero ? DONE : LOOP;
      end
      LOOP: begin
        if (loop_eq) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load: strip twos from each operand, keep the common power in k.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      gcd_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (ops_zero) begin
              gcd_q <= a_i | b_i;
            end else begin
              k_q <= tz_ab;
              a_q <= a_i >> tz_ad;
              b_q <= b_i >> tz_b;
            end
          end
        end
        LOOP: begin
          if (loop_eq) begin
            gcd_q <= a_q << k_q;
          end else begin
            a_q <= a_gt_b ? b_q : a_q;
            b_q <= diff >> tz_ad;
          end
        end
        default: ;
      endcase
    end
  end

  assign gcd_o = gcd_q;

`ifdef GCD_CYCLE_CNT_EN
  logic [GCD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && valid_i) begin
      cnt_q <= '0;
    end else if (state_q == LOOP) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cycles_o = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_stein16.sv
// Directed and randomized bench for gcd_stein16 against a Euclid-based reference.
module tb_gcd_stein16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] a_i = 16'd0;
  logic [15:0] b_i = 16'd0;
  logic        ready_o, valid_o;
  logic [15:0] gcd_o;
`ifdef GCD_CYCLE_CNT_EN
  logic [5:0]  cycles_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcd_stein16 dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
`ifdef GCD_CYCLE_CNT_EN
    .cycles_o (cycles_o),
`endif
    .gcd_o    (gcd_o)
  );

  function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] t;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the engine idle; returns edges from accept to valid_o.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic rdy,
                        output int lat);
    chk("idle_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    ready_i = rdy;
    @(negedge clk);
    valid_i = 1'b0;
    a_i     = 16'($urandom);
    b_i     = 16'($urandom);
    lat     = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_in_bound", 32'(valid_o), 32'd1);
  endtask

  task automatic take_result();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("ready_after_take", 32'(ready_o), 32'd1);
    chk("valid_after_take", 32'(valid_o), 32'd0);
  endtask

  task automatic gen_ops();
    int sel;
    logic [15:0] base;
    a_i = 16'($urandom);
    b_i = 16'($urandom);
    sel = $urandom_range(0, 7);
    base = 16'($urandom_range(1, 255));
    case (sel)
      0: a_i = 16'd0;
      1: b_i = 16'd0;
      2: begin
        a_i = 16'(base * $urandom_range(1, 200));
        b_i = 16'(base * $urandom_range(1, 200));
      end
      3: begin
        a_i = 16'(a_i << $urandom_range(0, 8));
        b_i = 16'(b_i << $urandom_range(0, 8));
      end
      default: ;
    endcase
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] q[$];
    logic [15:0] exp_v;
    int sent, got;
    bit acc, tak;
    localparam int NOPS = 40;

    // Reset values
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_gcd", 32'(gcd_o), 32'd0);
`ifdef GCD_CYCLE_CNT_EN
    chk("rst_cycles", 32'(cycles_o), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // gcd(48,18): k=1, a=3, b=9, two LOOP cycles
    run_op(16'd48, 16'd18, 1'b0, lat);
    chk("lat_48_18", 32'(lat), 32'd3);
    chk("gcd_48_18", 32'(gcd_o), 32'd6);
`ifdef GCD_CYCLE_CNT_EN
    chk("cyc_48_18", 32'(cycles_o), 32'd2);
`endif
    take_result();

    // Zero operands
    run_op(16'd0, 16'd20, 1'b1, lat);
    chk("lat_0_20", 32'(lat), 32'd1);
    chk("gcd_0_20", 32'(gcd_o), 32'd20);
`ifdef GCD_CYCLE_CNT_EN
    chk("cyc_0_20", 32'(cycles_o), 32'd0);
`endif
    take_result();
    run_op(16'd0, 16'd0, 1'b1, lat);
    chk("gcd_0_0", 32'(gcd_o), 32'd0);
    take_result();
    run_op(16'd65535, 16'd0, 1'b0, lat);
    chk("lat_ffff_0", 32'(lat), 32'd1);
    chk("gcd_ffff_0", 32'(gcd_o), 32'd65535);
    take_result();

    // Long iteration and maximal common power of two
    run_op(16'd65535, 16'd1, 1'b0, lat);
    chk("lat_ffff_1_bound", 32'(lat <= 33), 32'd1);
    chk("gcd_ffff_1", 32'(gcd_o), 32'd1);
    take_result();
    run_op(16'd32768, 16'd32768, 1'b1, lat);
    chk("lat_8000", 32'(lat), 32'd2);
    chk("gcd_8000", 32'(gcd_o), 32'd32768);
`ifdef GCD_CYCLE_CNT_EN
    chk("cyc_8000", 32'(cycles_o), 32'd1);
`endif
    take_result();

    // Back-pressure: result held, inputs ignored
    run_op(16'd48, 16'd18, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'($urandom);
      a_i     = 16'($urandom);
      b_i     = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_gcd", 32'(gcd_o), 32'd6);
      chk("hold_ready", 32'(ready_o), 32'd0);
    end
    valid_i = 1'b0;
    take_result();
    run_op(16'd7, 16'd5, 1'b1, lat);
    chk("gcd_7_5", 32'(gcd_o), 32'd1);
    take_result();

    // Asynchronous reset in the middle of an iteration
    valid_i = 1'b1;
    a_i     = 16'd1071;
    b_i     = 16'd462;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    chk("midloop_busy", 32'(ready_o), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_gcd", 32'(gcd_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_op(16'd1071, 16'd462, 1'b0, lat);
    chk("gcd_1071_462", 32'(gcd_o), 32'd21);
    take_result();

    // Random back-to-back traffic with random ready_i
    sent = 0;
    got  = 0;
    gen_ops();
    valid_i = 1'b1;
    for (int cyc = 0; cyc < 8000 && got < NOPS; cyc++) begin
      ready_i = 1'($urandom);
      acc = valid_i && ready_o;
      tak = valid_o && ready_i;
      chk("excl_valid_ready", 32'(valid_o & ready_o), 32'd0);
      if (tak) begin
        chk("rand_not_dup", 32'(q.size() > 0), 32'd1);
        exp_v = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        chk("rand_gcd", 32'(gcd_o), 32'(exp_v));
        got++;
      end
      if (acc) begin
        q.push_back(ref_gcd(a_i, b_i));
        sent++;
      end
      @(negedge clk);
      if (acc) begin
        if (sent < NOPS) gen_ops();
        else valid_i = 1'b0;
      end
    end
    ready_i = 1'b0;
    valid_i = 1'b0;
    chk("rand_all_results", 32'(got), 32'(NOPS));
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_stein16.md
# gcd_stein16

Iterative binary (Stein) GCD engine for two unsigned WIDTH-bit operands, with valid/ready handshakes on both sides. It consumes trailing-zero counts from the gcd block's trailing-zero counter: it uses each count as a right-shift amount to strip factors of two, and restores the common power of two with a final left shift. Within the gcd datapath it is the top-level compute unit. Each operation uses one register-load cycle plus one cycle per subtract/strip iteration.

## Interface
- WIDTH, 16, operand and result width; only 16 is supported, matching the trailing-zero counter.
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operand pair valid.
- ready_o  output  1  engine idle, will accept operands.
- a_i  input  WIDTH  operand A, unsigned.
- b_i  input  WIDTH  operand B, unsigned.
- valid_o  output  1  result valid; held until taken.
- ready_i  input  1  downstream accepts the result.
- gcd_o  output  WIDTH  gcd(A,B), registered.

## Operation
- States: IDLE, LOOP, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o (accept), capture the operands.
  - If A==0 or B==0: gcd_o <= A|B and go to DONE (this includes 0,0 -> 0).
  - Otherwise: k <= tz(A|B); a <= A>>tz(A); b <= B>>tz(B); go to LOOP.
- LOOP (a and b both odd):
  - If a==b: gcd_o <= a<<k, go to DONE.
  - Else: d=|a-b| (unsigned, no wrap); a <= min(a,b); b <= d>>tz(d); stay in LOOP.
  - d is never 0 in this branch.
- DONE:
  - valid_o=1.
  - On ready_i, go to IDLE.
  - gcd_o holds its value until the next result is written.
- Width rules:
  - k is 4 bits.
  - a<<k cannot overflow, because the true gcd fits in WIDTH.
- While LOOP/DONE, ready_o=0. valid_i and a_i/b_i are ignored, and captured operands are unaffected by input changes.
- Reset (any state, including mid-LOOP or DONE holding an untaken result):
  - Immediate return to IDLE; the pending result is discarded.
  - Output reset values: ready_o=1, valid_o=0, gcd_o=0.
  - Internal a, b, k also reset to 0.

## Timing
- Latency: valid_o rises N+1 rising edges after the accept edge, where N = number of LOOP cycles, including the equality cycle.
- Zero-operand case: valid_o is high 1 cycle after accept.
- Maximum N is 2*WIDTH.
- ready_o returns high the cycle after the valid_o&&ready_i edge, so back-to-back throughput is N+2 cycles.
- If ready_i is already high when valid_o rises, the result is taken in that same cycle.
- No combinational path exists from valid_i/ready_i to ready_o/valid_o; both are state decodes.

## Configuration
- Macro GCD_CYCLE_CNT_EN.
  - Defined: adds output cycles_o (6 bits) holding N for the current result.
    - Cleared on accept; incremented each LOOP cycle.
    - Valid while valid_o is high; reset value 0.
    - For a zero-operand result, cycles_o=0.
  - Undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Package gcd_pkg holds:
  - typedef enum logic [1:0] gcd_state_e {IDLE, LOOP, DONE};
  - localparam GCD_WIDTH=16;
  - localparam GCD_CNT_W=6.
- Sub-module: tzn16 trailing-zero counter, three instances:
  - tz(A|B), used for k;
  - a shared instance for tz(A) and tz(d), muxed by state;
  - tz(B).
- The all_zeros_o output of each instance is left unused.

## Test plan
- gcd(48,18): k=1, a=3, b=9 -> N=2; valid_o 3 cycles after accept; gcd_o=6; cycles_o=2 when enabled.
- gcd(0,20) -> gcd_o=20 one cycle after accept. gcd(0,0) -> 0. gcd(65535,0) -> 65535.
- gcd(65535,1) -> gcd_o=1 within 2*WIDTH+1 cycles. gcd(32768,32768) -> 32768, with N=1.
- Hold ready_i=0 for 10 cycles after valid_o rises: valid_o and gcd_o stay stable, ready_o stays 0, and toggling valid_i/a_i during this time is ignored.
- Assert rst_ni low mid-LOOP for gcd(1071,462): outputs go to reset values asynchronously. A fresh gcd(1071,462) after release returns 21.
- Random back-to-back operand pairs against a reference model: no lost or duplicated results, and the handshake holds under random ready_i.
